// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell; purely combinational.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half_adder cells; purely combinational.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    half_adder u_ha1 (
        .i_a     (w_s1),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (w_c2)
    );

    assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder; result valid WIDTH cycles after operand acceptance.
// Result is held in DONE until out_ready; in_ready is high only in IDLE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_carry;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_finish;
    logic             w_consume;
    logic [WIDTH-1:0] w_sum_nxt;

    full_adder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    // New sum bit enters at the MSB; written as a shift/OR so WIDTH=1 needs no special case.
    assign w_sum_nxt = (r_sum_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sr   <= in_a;
                r_b_sr   <= in_b;
                r_sum_sr <= '0;
                r_carry  <= 1'b0;
                r_cnt    <= '0;
            end
            if (w_shift) begin
                r_a_sr   <= r_a_sr >> 1;
                r_b_sr   <= r_b_sr >> 1;
                r_sum_sr <= w_sum_nxt;
                r_carry  <= w_c;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_finish) begin
                r_out_sum   <= w_sum_nxt;
                r_out_carry <= w_c;
                r_out_valid <= 1'b1;
            end
            if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_carry = r_out_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table, corner-case sequences, WIDTH=1 build, random scoreboard.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_carry;

    logic       in_valid1;
    logic       in_ready1;
    logic       in_a1;
    logic       in_b1;
    logic       out_valid1;
    logic       out_ready1;
    logic       out_sum1;
    logic       out_carry1;

    int n_vec = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_carry (out_carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 64) begin
            step();
            guard++;
        end
        if (guard >= 64) chk("accept_timeout", 32'(guard), 32'(0));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [7:0]  held_sum;
        logic        held_carry;
        logic [8:0]  exp_q[$];
        logic [8:0]  exp_v;
        int          sent;
        int          got;
        int          cyc;
        logic        acc;
        logic        fire;

        vecs[0] = '{8'h03, 8'h05, 8'h08, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h55, 8'hAA, 8'hFF, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_a1      = 1'b0;
        in_b1      = 1'b0;
        out_ready1 = 1'b1;
        #23;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_sum", 32'(out_sum), 32'(0));
        chk("rst_out_carry", 32'(out_carry), 32'(0));
        rst_n = 1'b1;
        step();

        // Directed table, out_ready held high.
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(8));
            chk($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_carry", i), 32'(out_carry), 32'(vecs[i].carry));
            chk($sformatf("vec%0d_in_ready_busy", i), 32'(in_ready), 32'(0));
            step();
            chk($sformatf("vec%0d_consumed", i), 32'(out_valid), 32'(0));
            chk($sformatf("vec%0d_in_ready_back", i), 32'(in_ready), 32'(1));
        end

        // Back-pressure: result held for 5 cycles with out_ready low.
        out_ready = 1'b0;
        start_op(8'hC3, 8'h5A);
        wait_valid(lat);
        held_sum   = out_sum;
        held_carry = out_carry;
        chk("bp_sum", 32'(held_sum), 32'(8'h1D));
        chk("bp_carry", 32'(held_carry), 32'(1));
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_valid_c%0d", k), 32'(out_valid), 32'(1));
            chk($sformatf("bp_sum_c%0d", k), 32'(out_sum), 32'(held_sum));
            chk($sformatf("bp_carry_c%0d", k), 32'(out_carry), 32'(held_carry));
            chk($sformatf("bp_in_ready_c%0d", k), 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        step();
        chk("bp_consumed", 32'(out_valid), 32'(0));
        chk("bp_in_ready", 32'(in_ready), 32'(1));

        // Busy stimulus: new operands presented during SHIFT must wait.
        start_op(8'h12, 8'h34);
        repeat (3) step();
        in_a = 8'h99;
        in_b = 8'h11;
        in_valid = 1'b1;
        chk("busy_in_ready", 32'(in_ready), 32'(0));
        wait_valid(lat);
        chk("busy_lat", 32'(lat), 32'(5));
        chk("busy_sum1", 32'(out_sum), 32'(8'h46));
        chk("busy_carry1", 32'(out_carry), 32'(0));
        step();
        chk("busy_in_ready_back", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("busy_lat2", 32'(lat), 32'(8));
        chk("busy_sum2", 32'(out_sum), 32'(8'hAA));
        chk("busy_carry2", 32'(out_carry), 32'(0));
        step();

        // Asynchronous reset in the middle of SHIFT (cnt=3).
        start_op(8'hEE, 8'h77);
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_out_valid", 32'(out_valid), 32'(0));
        start_op(8'h10, 8'h20);
        wait_valid(lat);
        chk("post_rst_lat", 32'(lat), 32'(8));
        chk("post_rst_sum", 32'(out_sum), 32'(8'h30));
        chk("post_rst_carry", 32'(out_carry), 32'(0));
        step();

        // WIDTH=1 build: 1+1.
        in_a1 = 1'b1;
        in_b1 = 1'b1;
        in_valid1 = 1'b1;
        chk("w1_in_ready", 32'(in_ready1), 32'(1));
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 16) begin
            step();
            lat++;
        end
        chk("w1_lat", 32'(lat), 32'(1));
        chk("w1_sum", 32'(out_sum1), 32'(0));
        chk("w1_carry", 32'(out_carry1), 32'(1));
        step();
        chk("w1_consumed", 32'(out_valid1), 32'(0));

        // Random operands and random out_ready against a+b scoreboard.
        sent = 0;
        got  = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            if (!in_valid && sent < 1000) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_result", 32'({out_carry, out_sum}), 32'h1FF);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk($sformatf("rnd%0d", got), 32'({out_carry, out_sum}), 32'(exp_v));
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
                sent++;
            end
            step();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        if (got < 1000) chk("rnd_timeout", 32'(got), 32'(1000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
